fetch_queue: RTL and testbench

Parametrised successor to the single-register fetch stage. Owns its own fetch pointer and issues one instruction-memory read per cycle while queue space allows. Buffers returned instructions, tagged with their PC and a fault flag, in a DEPTH-entry FIFO. Presents them to execution control over a valid/ready handshake. Sits between the DROM/decode pair and the control logic, and replaces hold-based stalling with backpressure and flush-with-redirect.

---
 rtl/params_pkg.sv | 13 +
 rtl/fetch_queue_if.sv | 32 +++
 rtl/fetch_queue_fifo.sv | 55 +++++
 rtl/fetch_queue.sv | 88 ++++++++
 tb/tb_fetch_queue.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/params_pkg.sv
// Shared fetch-path parameters and the fetch queue entry type.
package params_pkg;
  localparam int ADDR_W = 8;
  localparam int INSTR_W = 16;
  localparam logic [2:0] DROM = 3'd1;
  localparam int FETCHQ_DEPTH = 4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic               fault;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// Fetch queue bus: memory/decode side plus consumer handshake side.
interface fetch_queue_if
  import params_pkg::*;
#(
  parameter int DEPTH = FETCHQ_DEPTH
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic               flush;
  logic [ADDR_W-1:0]  redirect_pc;
  logic [ADDR_W-1:0]  addr;
  logic               rd;
  logic               hit;
  logic [2:0]         did;
  logic [INSTR_W-1:0] drom_data;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               fault;
  logic               valid;
  logic               ready;
  logic [LVL_W-1:0]   level;

  modport master (
    input  flush, redirect_pc, hit, did, drom_data, ready,
    output addr, rd, instr, instr_pc, fault, valid, level
  );

  modport slave (
    output flush, redirect_pc, hit, did, drom_data, ready,
    input  addr, rd, instr, instr_pc, fault, valid, level
  );
endinterface

// File: rtl/fetch_queue_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries; head is read combinationally.
module fetch_fifo
  import params_pkg::*;
#(
  parameter int DEPTH = FETCHQ_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg          <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  assign head  = mem_reg[rd_ptr_reg];
  assign level = level_reg;
endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: owns the fetch pointer, issues one DROM read per cycle while a
// slot is free, and queues returned instructions behind a valid/ready handshake.
module fetch_queue
  import params_pkg::*;
#(
  parameter int                DEPTH    = FETCHQ_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 1
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] req_pc_reg;
  logic              req_ok_reg;
  logic              inflight_reg;
  logic              halted_reg;

  logic [LVL_W-1:0]  level_w;
  logic [LVL_W:0]    occupancy_w;
  logic              issue_w;
  logic              hit_ok_w;
  logic              push_w;
  logic              pop_w;
  fetch_entry_t      push_entry_w;
  fetch_entry_t      head_w;

  // Every in-flight read holds a reserved slot, so a push never overflows.
  assign occupancy_w = {1'b0, level_w} + {{LVL_W{1'b0}}, inflight_reg};
  assign issue_w     = rst & ~bus.flush & ~halted_reg &
                       (occupancy_w < (LVL_W+1)'(DEPTH));
  assign hit_ok_w    = bus.hit && (bus.did == DROM);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_reg       <= RESET_PC;
      req_pc_reg   <= '0;
      req_ok_reg   <= 1'b0;
      inflight_reg <= 1'b0;
      halted_reg   <= 1'b0;
    end else if (bus.flush) begin
      pc_reg       <= bus.redirect_pc;
      inflight_reg <= 1'b0;
      halted_reg   <= 1'b0;
    end else if (issue_w) begin
      pc_reg       <= pc_reg + ADDR_W'(PC_STEP);
      req_pc_reg   <= pc_reg;
      req_ok_reg   <= hit_ok_w;
      inflight_reg <= 1'b1;
      // A read outside DROM is still queued as a fault, then fetch stops.
      if (!hit_ok_w) begin
        halted_reg <= 1'b1;
      end
    end else begin
      inflight_reg <= 1'b0;
    end
  end

  assign push_w             = inflight_reg & ~bus.flush;
  assign pop_w              = bus.valid & bus.ready;
  assign push_entry_w.instr = req_ok_reg ? bus.drom_data : '0;
  assign push_entry_w.pc    = req_pc_reg;
  assign push_entry_w.fault = ~req_ok_reg;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (bus.flush),
    .push      (push_w),
    .push_data (push_entry_w),
    .pop       (pop_w),
    .head      (head_w),
    .level     (level_w)
  );

  assign bus.addr     = pc_reg;
  assign bus.rd       = issue_w;
  assign bus.instr    = head_w.instr;
  assign bus.instr_pc = head_w.pc;
  assign bus.fault    = head_w.fault;
  assign bus.valid    = (level_w != '0);
  assign bus.level    = level_w;
endmodule

// File: tb/tb_fetch_queue.sv
// Random-stimulus bench for fetch_queue: a queue-based reference model predicts
// every entry; a negedge monitor compares the DUT against it.
module tb_fetch_queue;
  import params_pkg::*;

  localparam int                DEPTH    = 4;
  localparam logic [ADDR_W-1:0] RESET_PC = 8'h10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC),
    .PC_STEP (1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Memory map and contents seen by the fetch stage.
  bit               unmapped [256];
  logic [2:0]       dev_of   [256];
  logic [INSTR_W-1:0] drom_q;

  function automatic logic [INSTR_W-1:0] mem_f(input logic [ADDR_W-1:0] a);
    return {a ^ 8'hA5, a + 8'h3C};
  endfunction

  function automatic bit addr_ok(input logic [ADDR_W-1:0] a);
    return !unmapped[a] && (dev_of[a] == DROM);
  endfunction

  assign bus.hit       = ~unmapped[bus.addr];
  assign bus.did       = dev_of[bus.addr];
  assign bus.drom_data = drom_q;
  always @(posedge clk) drom_q <= mem_f(bus.addr);

  // Reference model state.
  fetch_entry_t      sb_q [$];
  logic [ADDR_W-1:0] exp_pc = RESET_PC;
  bit                pend = 0;
  logic [ADDR_W-1:0] pend_addr = '0;
  bit                pend_ok = 0;
  bit                halted = 0;
  bit                issue_now = 0;
  bit                started = 0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the rules of one clock edge, applied to queue/pointer abstractions.
  always @(posedge clk) begin
    started = 1;
    if (!rst) begin
      sb_q.delete();
      exp_pc = RESET_PC;
      pend   = 0;
      halted = 0;
    end else if (bus.flush) begin
      sb_q.delete();
      exp_pc = bus.redirect_pc;
      pend   = 0;
      halted = 0;
    end else begin
      if (pend) begin
        fetch_entry_t e;
        e.instr = pend_ok ? mem_f(pend_addr) : '0;
        e.pc    = pend_addr;
        e.fault = !pend_ok;
        sb_q.push_back(e);
      end
      pend = 0;
      if (issue_now) begin
        pend      = 1;
        pend_addr = exp_pc;
        pend_ok   = addr_ok(exp_pc);
        if (!pend_ok) halted = 1;
        exp_pc = exp_pc + 8'd1;
      end
    end
  end

  // Monitor: compare outputs mid-cycle and retire the head on an accepting edge.
  always @(negedge clk) begin
    if (started) begin
      bit exp_rd;
      exp_rd = rst && !bus.flush && !halted && (sb_q.size() + int'(pend) < DEPTH);
      chk("rd", 32'(bus.rd), 32'(exp_rd));
      chk("addr", 32'(bus.addr), 32'(exp_pc));
      chk("level", 32'(bus.level), 32'(sb_q.size()));
      chk("valid", 32'(bus.valid), 32'(sb_q.size() != 0));
      if (sb_q.size() > 0) begin
        chk("instr", 32'(bus.instr), 32'(sb_q[0].instr));
        chk("instr_pc", 32'(bus.instr_pc), 32'(sb_q[0].pc));
        chk("fault", 32'(bus.fault), 32'(sb_q[0].fault));
        if (rst && !bus.flush && bus.ready) begin
          $display("pop pc=%02h instr=%04h fault=%0b", sb_q[0].pc, sb_q[0].instr, sb_q[0].fault);
          void'(sb_q.pop_front());
        end
      end
      issue_now = exp_rd;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      unmapped[a] = 0;
      dev_of[a]   = DROM;
    end
    unmapped[8'h20] = 1;
    dev_of[8'h4c]   = 3'd2;
    rst = 1'b0;
    bus.flush = 1'b0;
    bus.redirect_pc = '0;
    bus.ready = 1'b0;
    cyc(3);

    // Streaming from RESET_PC until the unmapped 0x20 halts fetch.
    rst = 1'b1;
    bus.ready = 1'b1;
    cyc(25);

    // Redirect, then fill with ready low.
    bus.flush = 1'b1;
    bus.redirect_pc = 8'h30;
    cyc(1);
    bus.flush = 1'b0;
    bus.ready = 1'b0;
    cyc(12);

    // Single pop, then flush while level 3 with a read in flight.
    bus.ready = 1'b1;
    cyc(1);
    bus.ready = 1'b0;
    cyc(1);
    bus.flush = 1'b1;
    bus.redirect_pc = 8'h40;
    cyc(1);
    bus.flush = 1'b0;
    bus.ready = 1'b1;
    cyc(20);

    // Fetch pointer wrap through 0xff.
    bus.flush = 1'b1;
    bus.redirect_pc = 8'hfa;
    cyc(1);
    bus.flush = 1'b0;
    cyc(12);
    bus.ready = 1'b0;
    cyc(3);
    bus.ready = 1'b1;
    cyc(10);

    // Reset and flush together, with ready high and a response due.
    rst = 1'b0;
    bus.flush = 1'b1;
    bus.redirect_pc = 8'h77;
    cyc(1);
    rst = 1'b1;
    bus.flush = 1'b0;
    cyc(8);

    for (int i = 0; i < 300; i++) begin
      bus.ready = ($urandom_range(0, 9) < 7);
      bus.flush = ($urandom_range(0, 29) == 0);
      bus.redirect_pc = 8'($urandom);
      cyc(1);
    end
    bus.flush = 1'b0;
    bus.ready = 1'b1;
    cyc(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
